mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly after the execute stage and before write-back.
- Accepts the execute stage's result, load type and exception bundle through a valid/allowin handshake.
- Waits for the in-order data-SRAM response (data_ok) of a load or store issued by execute, then aligns and sign/zero-extends load data.
- Exports a forwarding/stall bundle for decode, handles exception flush, and discards responses belonging to cancelled requests.

Parameters:
- None. All widths are fixed by the 32-bit ISA.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- es_to_ms_valid  in  1  execute has an instruction for this stage
- ms_allowin  out  1  this stage can accept an instruction this cycle
- es_pc  in  32  pc of the incoming instruction
- es_rf_collect  in  39  {res_from_mem, rf_we, rf_waddr[4:0], result[31:0]}; result is the ALU address for memory instructions
- es_ld_op  in  5  one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}
- es_except  in  7  {ale, adef, ine, syscall, break, int, ertn}
- es_mem_req  in  1  execute's data request was accepted (addr_ok seen)
- es_cancel_req  in  1  during except_flush, execute holds an accepted request that has not been handed to this stage
- data_sram_data_ok  in  1  in-order response strobe
- data_sram_rdata  in  32  response data
- except_flush  in  1  exception/ertn flush
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  output instruction valid
- ms_pc  out  32  registered pc
- ms_to_ws_bus  out  38  {rf_we, rf_waddr[4:0], final_result[31:0]}
- ms_rf_collect  out  39  {ms_wait_load, rf_we & ms_valid, rf_waddr, final_result}; used by decode for forwarding and stalls
- ms_except  out  7  registered es_except, forced to 0 when ms_valid=0

Behaviour:
- Reset: ms_valid, all payload registers, buffer, drop_cnt and every output are 0. ms_allowin=1 after reset.
- Handshake:
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go.
  - On es_to_ms_valid & ms_allowin, latch the payload; ms_valid <= 1. Otherwise, if ms_allowin, ms_valid <= 0.
  - except_flush clears ms_valid with priority over the latch.
- Memory wait:
  - need_data is registered es_mem_req at latch.
  - got_data is set by data_ok when ms_valid & need_data & drop_cnt==0.
  - When data_ok arrives before the handoff, rdata is captured into rbuf.
  - ms_ready_go = ~need_data | got_data | (data_ok & drop_cnt==0). Data_ok in the same cycle forwards rdata combinationally (zero-cycle bypass).
  - got_data and rbuf are cleared on handoff (ms_to_ws_valid & ws_allowin) and on flush.
  - ms_wait_load = ms_valid & res_from_mem & ~ms_ready_go.
- Drop counter (2-bit, saturating at 3):
  - drop_cnt_next = drop_cnt − (data_ok & drop_cnt!=0) + (except_flush ? (ms_valid & need_data & ~got_data & ~(data_ok & drop_cnt==0)) + es_cancel_req : 0).
  - A data_ok consumed by the drop counter is never used as data.
  - Simultaneous flush and data_ok with drop_cnt==0: the response belongs to the flushed MEM instruction. It is consumed and not counted.
- Load extension: offset = result[1:0].
  - ld_b/ld_bu: select byte[offset], then sign- or zero-extend.
  - ld_h/ld_hu: select half[offset[1]], then sign- or zero-extend.
  - ld_w: full word.
  - final_result = res_from_mem ? load_data : result.
- Exceptions: if any ms_except bit is set, need_data is forced to 0 and rf_we is masked to 0 in both buses.
- Stall/flush: payload is held stable while ms_valid & ~ms_allowin.

Test Plan:
- Store, data_ok 3 cycles later: ms_to_ws_valid is 0 for the 2 wait cycles and rises in the data_ok cycle. ms_allowin is 0 while waiting.
- ld_b, addr 0x1002, rdata 0x12_80_34_56: final_result = 0xFFFFFF80. Same with ld_bu: 0x00000080. ld_h at 0x1002: 0x00001280.
- Load, data_ok arrives while ws_allowin=0 for 2 cycles: rbuf holds the value, ms_to_ws_valid stays 1 with the correct data, and handoff happens when ws_allowin=1. ms_wait_load=0 after data_ok.
- Flush while a load waits in MEM and es_cancel_req=1: drop_cnt=2. The next two data_ok (0xAAAA, 0xBBBB) are ignored. A new load's third response 0xCCCC0001 (ld_w, addr 0x..0) gives final_result = 0xCCCC0001.
- Flush in the same cycle as data_ok, with es_cancel_req=0 and drop_cnt=0: drop_cnt stays 0 and the next data_ok is used as data.
- es_except=ale with es_mem_req=0: ms_ready_go is immediate, ms_except=7'b1000000, rf_we in ms_rf_collect is 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Waits for the in-order data-SRAM response, extends load data, exports the
// forwarding/stall bundle and drops responses that belong to flushed requests.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [38:0] es_rf_collect,
    input  logic [4:0]  es_ld_op,
    input  logic [6:0]  es_except,
    input  logic        es_mem_req,
    input  logic        es_cancel_req,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        except_flush,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [37:0] ms_to_ws_bus,
    output logic [38:0] ms_rf_collect,
    output logic [6:0]  ms_except
);

    localparam int unsigned XLEN         = 32;
    localparam int unsigned COLLECT_W    = 39;
    localparam int unsigned RES_FROM_MEM = 38;
    localparam int unsigned RF_WE        = 37;
    localparam int unsigned LD_W_BIT     = 4;
    localparam int unsigned LD_H_BIT     = 3;
    localparam int unsigned LD_HU_BIT    = 2;
    localparam int unsigned LD_B_BIT     = 1;
    localparam int unsigned LD_BU_BIT    = 0;

    logic                 ms_valid;
    logic [COLLECT_W-1:0] rf_collect_r;
    logic [4:0]           ld_op_r;
    logic [6:0]           except_r;
    logic                 need_data;
    logic                 got_data;
    logic [XLEN-1:0]      rbuf;
    logic [1:0]           drop_cnt;
    logic [1:0]           drop_cnt_next;

    logic                 data_use;
    logic                 ms_ready_go;
    logic                 handoff;
    logic                 rf_we_eff;
    logic                 ms_wait_load;
    logic [XLEN-1:0]      result;
    logic [1:0]           offset;
    logic [XLEN-1:0]      load_word;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [XLEN-1:0]      load_data;
    logic [XLEN-1:0]      final_result;

    // A response only counts as data when no dropped response is still owed
    assign data_use       = data_sram_data_ok & (drop_cnt == 2'd0);
    assign ms_ready_go    = ~need_data | got_data | data_use;
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign handoff        = ms_to_ws_valid & ws_allowin;

    assign result    = rf_collect_r[XLEN-1:0];
    assign offset    = result[1:0];
    assign load_word = got_data ? rbuf : data_sram_rdata;
    assign ld_byte   = load_word[{offset, 3'b000} +: 8];
    assign ld_half   = offset[1] ? load_word[31:16] : load_word[15:0];

    // Load alignment and sign/zero extension
    always_comb begin
        load_data = load_word;
        if (ld_op_r[LD_W_BIT]) begin
            load_data = load_word;
        end else if (ld_op_r[LD_H_BIT]) begin
            load_data = {{16{ld_half[15]}}, ld_half};
        end else if (ld_op_r[LD_HU_BIT]) begin
            load_data = {16'd0, ld_half};
        end else if (ld_op_r[LD_B_BIT]) begin
            load_data = {{24{ld_byte[7]}}, ld_byte};
        end else if (ld_op_r[LD_BU_BIT]) begin
            load_data = {24'd0, ld_byte};
        end
    end

    assign final_result = rf_collect_r[RES_FROM_MEM] ? load_data : result;
    assign rf_we_eff    = rf_collect_r[RF_WE] & ~(|except_r);
    assign ms_wait_load = ms_valid & rf_collect_r[RES_FROM_MEM] & ~ms_ready_go;

    assign ms_to_ws_bus  = {rf_we_eff, rf_collect_r[36:32], final_result};
    assign ms_rf_collect = {ms_wait_load, rf_we_eff & ms_valid, rf_collect_r[36:32], final_result};
    assign ms_except     = ms_valid ? except_r : 7'd0;

    // Count responses still owed to requests killed by a flush (saturating)
    always_comb begin
        logic       dec;
        logic [1:0] inc;
        logic [2:0] sum;
        dec = data_sram_data_ok & (drop_cnt != 2'd0);
        inc = 2'd0;
        if (except_flush) begin
            inc = 2'(ms_valid & need_data & ~got_data & ~data_use) + 2'(es_cancel_req);
        end
        sum = 3'(drop_cnt) - 3'(dec) + 3'(inc);
        drop_cnt_next = (sum > 3'd3) ? 2'd3 : sum[1:0];
    end

    // Valid bit and payload capture from execute
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid     <= 1'b0;
            ms_pc        <= '0;
            rf_collect_r <= '0;
            ld_op_r      <= '0;
            except_r     <= '0;
            need_data    <= 1'b0;
        end else begin
            if (except_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid & ms_allowin & ~except_flush) begin
                ms_pc        <= es_pc;
                rf_collect_r <= es_rf_collect;
                ld_op_r      <= es_ld_op;
                except_r     <= es_except;
                need_data    <= es_mem_req & ~(|es_except);
            end
        end
    end

    // Hold an early response until write-back takes the instruction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            got_data <= 1'b0;
            rbuf     <= '0;
        end else if (except_flush | handoff) begin
            got_data <= 1'b0;
            rbuf     <= '0;
        end else if (ms_valid & need_data & data_use & ~got_data) begin
            got_data <= 1'b1;
            rbuf     <= data_sram_rdata;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt <= 2'd0;
        end else begin
            drop_cnt <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, directed corner sequences and a randomized run
// against a queue-based model of the response stream for mem_stage.
module tb_mem_stage;

    localparam logic [4:0] LD_W  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b00100;
    localparam logic [4:0] LD_B  = 5'b00010;
    localparam logic [4:0] LD_BU = 5'b00001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [38:0] es_rf_collect;
    logic [4:0]  es_ld_op;
    logic [6:0]  es_except;
    logic        es_mem_req;
    logic        es_cancel_req;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        except_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [37:0] ms_to_ws_bus;
    logic [38:0] ms_rf_collect;
    logic [6:0]  ms_except;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_rf_collect     (es_rf_collect),
        .es_ld_op          (es_ld_op),
        .es_except         (es_except),
        .es_mem_req        (es_mem_req),
        .es_cancel_req     (es_cancel_req),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .except_flush      (except_flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_rf_collect     (ms_rf_collect),
        .ms_except         (ms_except)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  op;
        logic        rfm;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        rfm;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] res;
        logic [4:0]  op;
        logic [6:0]  exc;
        logic        req;
    } inst_t;

    // Outstanding responses in issue order; owner < 0 marks a killed request
    typedef struct {
        int owner;
        int ready;
    } resp_t;

    vec_t  vt[10];
    resp_t rq[$];
    inst_t ex, mi;
    bit    ex_v, mi_v, mi_got;
    logic [31:0] mi_buf;
    int    next_id;
    int    k, dead;
    bit    flush, cancel, dok, use_now, need, rdy, handoff;
    bit    e_allow, e_val, e_wait, e_we;
    logic [31:0] word, fin, rdat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        es_pc             = '0;
        es_rf_collect     = '0;
        es_ld_op          = '0;
        es_except         = '0;
        es_mem_req        = 1'b0;
        es_cancel_req     = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        except_flush      = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    task automatic set_es(input logic [31:0] pc, input logic rfm, input logic we,
                          input logic [4:0] wa, input logic [31:0] res,
                          input logic [4:0] op, input logic [6:0] exc, input logic req);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_rf_collect  = {rfm, we, wa, res};
        es_ld_op       = op;
        es_except      = exc;
        es_mem_req     = req;
    endtask

    // Load result from the ISA rules, with plain arithmetic
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) % 256;
        h = (w >> (16 * (int'(off) / 2))) % 65536;
        if (op == LD_B)  return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
        if (op == LD_BU) return 32'(b);
        if (op == LD_H)  return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
        if (op == LD_HU) return 32'(h);
        return w;
    endfunction

    task automatic kill(input int id);
        foreach (rq[j]) if (rq[j].owner == id) rq[j].owner = -1;
    endtask

    initial begin
        vt[0] = '{LD_B,  1'b1, 32'h00001002, 32'h12803456, 32'hFFFFFF80};
        vt[1] = '{LD_BU, 1'b1, 32'h00001002, 32'h12803456, 32'h00000080};
        vt[2] = '{LD_H,  1'b1, 32'h00001002, 32'h12803456, 32'h00001280};
        vt[3] = '{LD_HU, 1'b1, 32'h00001000, 32'h1280F456, 32'h0000F456};
        vt[4] = '{LD_H,  1'b1, 32'h00001000, 32'h1280F456, 32'hFFFFF456};
        vt[5] = '{LD_B,  1'b1, 32'h00001003, 32'h92345678, 32'hFFFFFF92};
        vt[6] = '{LD_BU, 1'b1, 32'h00001000, 32'h000000FF, 32'h000000FF};
        vt[7] = '{LD_B,  1'b1, 32'h00001001, 32'h00007F00, 32'h0000007F};
        vt[8] = '{LD_W,  1'b1, 32'h00001004, 32'hCAFEF00D, 32'hCAFEF00D};
        vt[9] = '{5'b0,  1'b0, 32'h13572468, 32'hFFFFFFFF, 32'h13572468};

        // Reset state
        idle();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        #2;
        check("reset_handshake", {ms_allowin, ms_to_ws_valid}, 2'b10);
        check("reset_buses", {ms_pc, ms_to_ws_bus, ms_rf_collect, ms_except}, '0);
        tick();

        // Load extension vectors: instruction latched, response next cycle
        for (int i = 0; i < 10; i++) begin
            set_es(32'h100 + 32'(i * 4), vt[i].rfm, 1'b1, 5'd3, vt[i].addr, vt[i].op, 7'd0, vt[i].rfm);
            tick();
            es_to_ms_valid = 1'b0;
            if (vt[i].rfm) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vt[i].rdata;
            end
            #2;
            check($sformatf("vec%0d", i), {ms_to_ws_valid, ms_to_ws_bus}, {1'b1, 1'b1, 5'd3, vt[i].exp});
            tick();
            data_sram_data_ok = 1'b0;
        end

        // Store whose response arrives three cycles after it enters
        set_es(32'h200, 1'b0, 1'b0, 5'd0, 32'h1000, 5'd0, 7'd0, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        check("store_wait1", {ms_to_ws_valid, ms_allowin}, 2'b00);
        tick();
        #2;
        check("store_wait2", {ms_to_ws_valid, ms_allowin}, 2'b00);
        tick();
        data_sram_data_ok = 1'b1;
        #2;
        check("store_done", {ms_to_ws_valid, ms_allowin}, 2'b11);
        tick();
        data_sram_data_ok = 1'b0;
        #2;
        check("store_gone", ms_to_ws_valid, 1'b0);

        // Load response while write-back stalls: buffered value must persist
        set_es(32'h300, 1'b1, 1'b1, 5'd7, 32'h1002, LD_H, 7'd0, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        check("ld_wait", {ms_to_ws_valid, ms_rf_collect[38]}, 2'b01);
        tick();
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h12803456;
        #2;
        check("ld_stall0", {ms_to_ws_valid, ms_rf_collect[38], ms_to_ws_bus},
              {1'b1, 1'b0, 1'b1, 5'd7, 32'h00001280});
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEADBEEF;
        for (int i = 1; i <= 2; i++) begin
            #2;
            check($sformatf("ld_stall%0d", i), {ms_to_ws_valid, ms_allowin, ms_rf_collect[38], ms_to_ws_bus},
                  {1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h00001280});
            if (i == 2) ws_allowin = 1'b1;
            if (i == 1) tick();
        end
        #2;
        check("ld_release", {ms_to_ws_valid, ms_allowin, ms_to_ws_bus},
              {1'b1, 1'b1, 1'b1, 5'd7, 32'h00001280});
        tick();
        #2;
        check("ld_gone", ms_to_ws_valid, 1'b0);

        // Flush of a waiting load plus a cancelled execute request
        set_es(32'h400, 1'b1, 1'b1, 5'd9, 32'h1000, LD_W, 7'd0, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        except_flush   = 1'b1;
        es_cancel_req  = 1'b1;
        tick();
        except_flush  = 1'b0;
        es_cancel_req = 1'b0;
        set_es(32'h404, 1'b1, 1'b1, 5'd10, 32'h2000, LD_W, 7'd0, 1'b1);
        #2;
        check("flush_allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000AAAA;
        #2;
        check("drop_a", {ms_to_ws_valid, ms_rf_collect[38]}, 2'b01);
        tick();
        data_sram_rdata = 32'h0000BBBB;
        #2;
        check("drop_b", {ms_to_ws_valid, ms_rf_collect[38]}, 2'b01);
        tick();
        data_sram_rdata = 32'hCCCC0001;
        #2;
        check("drop_then_use", {ms_to_ws_valid, ms_to_ws_bus}, {1'b1, 1'b1, 5'd10, 32'hCCCC0001});
        tick();
        data_sram_data_ok = 1'b0;

        // Flush coinciding with the waiting load's own response
        set_es(32'h500, 1'b1, 1'b1, 5'd11, 32'h3000, LD_W, 7'd0, 1'b1);
        tick();
        es_to_ms_valid    = 1'b0;
        except_flush      = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD0000;
        tick();
        except_flush      = 1'b0;
        data_sram_data_ok = 1'b0;
        set_es(32'h504, 1'b1, 1'b1, 5'd12, 32'h3004, LD_W, 7'd0, 1'b1);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55551234;
        #2;
        check("flush_same_cycle", {ms_to_ws_valid, ms_to_ws_bus}, {1'b1, 1'b1, 5'd12, 32'h55551234});
        tick();
        data_sram_data_ok = 1'b0;

        // Address-error load: no memory wait, write enable suppressed
        set_es(32'h600, 1'b1, 1'b1, 5'd5, 32'h1001, LD_W, 7'b1000000, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        check("ale_out", {ms_to_ws_valid, ms_except, ms_rf_collect[38:37], ms_to_ws_bus[37]},
              {1'b1, 7'b1000000, 2'b00, 1'b0});
        tick();
        #2;
        check("ale_gone", {ms_to_ws_valid, ms_except}, 8'd0);

        // Randomized run against the response-ownership model
        resetn = 1'b0;
        idle();
        tick();
        resetn  = 1'b1;
        ex_v    = 1'b0;
        mi_v    = 1'b0;
        mi_got  = 1'b0;
        mi_buf  = '0;
        next_id = 0;
        ex      = '{0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 7'd0, 1'b0};
        mi      = ex;
        rq.delete();
        for (int c = 0; c < 3000; c++) begin
            if (!ex_v && $urandom_range(2) != 0) begin
                k      = int'($urandom_range(5));
                ex.id  = next_id;
                next_id++;
                ex.pc  = $urandom;
                ex.wa  = 5'($urandom);
                ex.res = $urandom;
                ex.rfm = (k == 1 || k == 3 || k == 5);
                ex.we  = (k != 2);
                ex.op  = ex.rfm ? 5'(1 << $urandom_range(4)) : 5'd0;
                ex.exc = (k == 3) ? 7'b1000000 : (k == 4) ? 7'(1 << $urandom_range(4)) : 7'd0;
                ex.req = (k == 1 || k == 2 || k == 5);
                if (ex.req) rq.push_back('{ex.id, c + int'($urandom_range(3))});
                ex_v = 1'b1;
            end
            dead = 0;
            foreach (rq[j]) if (rq[j].owner < 0) dead++;
            ws_allowin = ($urandom_range(3) != 0);
            flush      = (dead <= 1) && ($urandom_range(19) == 0);
            cancel     = flush && ex_v && ex.req;
            dok        = 1'b0;
            if (rq.size() > 0 && c >= rq[0].ready && $urandom_range(1) == 1) begin
                if (rq[0].owner < 0) dok = 1'b1;
                else if (mi_v && rq[0].owner == mi.id && !mi_got) dok = 1'b1;
            end
            rdat = $urandom;

            es_to_ms_valid    = ex_v;
            es_pc             = ex.pc;
            es_rf_collect     = {ex.rfm, ex.we, ex.wa, ex.res};
            es_ld_op          = ex.op;
            es_except         = ex.exc;
            es_mem_req        = ex.req;
            es_cancel_req     = cancel;
            except_flush      = flush;
            data_sram_data_ok = dok;
            data_sram_rdata   = rdat;

            use_now = dok && rq[0].owner >= 0;
            need    = mi.req && (mi.exc == 7'd0);
            rdy     = !need || mi_got || use_now;
            word    = mi_got ? mi_buf : rdat;
            fin     = mi.rfm ? ref_load(mi.op, mi.res[1:0], word) : mi.res;
            e_allow = !mi_v || (rdy && ws_allowin);
            e_val   = mi_v && rdy;
            e_wait  = mi_v && mi.rfm && !rdy;
            e_we    = mi.we && (mi.exc == 7'd0);
            #2;
            check($sformatf("rand_ctl@%0d", c),
                  {ms_allowin, ms_to_ws_valid, ms_rf_collect[38:37], ms_except},
                  {e_allow, e_val, e_wait, e_we && mi_v, mi_v ? mi.exc : 7'd0});
            if (mi_v) begin
                check($sformatf("rand_data@%0d", c),
                      {ms_pc, ms_to_ws_bus, ms_rf_collect[36:0]},
                      {mi.pc, e_we, mi.wa, fin, mi.wa, fin});
            end

            handoff = e_val && ws_allowin;
            if (dok) begin
                void'(rq.pop_front());
                if (use_now && !handoff && !flush) begin
                    mi_got = 1'b1;
                    mi_buf = rdat;
                end
            end
            if (flush) begin
                if (mi_v && need && !mi_got && !use_now) kill(mi.id);
                if (cancel) kill(ex.id);
                mi_v   = 1'b0;
                ex_v   = 1'b0;
                mi_got = 1'b0;
            end else begin
                if (handoff) mi_got = 1'b0;
                if (ex_v && e_allow) begin
                    mi     = ex;
                    mi_v   = 1'b1;
                    mi_got = 1'b0;
                    ex_v   = 1'b0;
                end else if (e_allow) begin
                    mi_v = 1'b0;
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
